// File: rtl/tri_geom_pkg.sv
// Shared widths and point/vector types for the triangle edge cross-product unit.
package tri_geom_pkg;

    localparam int DEF_SYS_BIT_WIDTH = 6;
    // Edge components need one extra bit to hold the sign of B - A.
    localparam int VEC_W = DEF_SYS_BIT_WIDTH + 1;
    // Each product needs 2*VEC_W bits; the difference of two products is still exact in this width.
    localparam int CP_W  = 2 * DEF_SYS_BIT_WIDTH + 2;

    typedef struct packed {
        logic [DEF_SYS_BIT_WIDTH-1:0] x;
        logic [DEF_SYS_BIT_WIDTH-1:0] y;
    } point_t;

    typedef struct packed {
        logic signed [VEC_W-1:0] x;
        logic signed [VEC_W-1:0] y;
    } vec_t;

endpackage

// File: rtl/point_sub.sv
// Combinational edge vector d = b - a from two unsigned screen points.
import tri_geom_pkg::*;

module point_sub (
    input  point_t a_i,
    input  point_t b_i,
    output vec_t   d_o
);

    // Zero-extend both coordinates so the signed difference cannot overflow.
    assign d_o.x = $signed({1'b0, b_i.x}) - $signed({1'b0, a_i.x});
    assign d_o.y = $signed({1'b0, b_i.y}) - $signed({1'b0, a_i.y});

endmodule

// File: rtl/tri_edge_cross.sv
// Three-stage pipelined 2D cross product of edges AB and AC:
// stage 1 edge vectors, stage 2 products, stage 3 difference plus sign/zero flags.
import tri_geom_pkg::*;

module tri_edge_cross #(
    parameter int SYS_BIT_WIDTH = DEF_SYS_BIT_WIDTH
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           valid_in,
    input  logic [SYS_BIT_WIDTH-1:0]       point_ax,
    input  logic [SYS_BIT_WIDTH-1:0]       point_ay,
    input  logic [SYS_BIT_WIDTH-1:0]       point_bx,
    input  logic [SYS_BIT_WIDTH-1:0]       point_by,
    input  logic [SYS_BIT_WIDTH-1:0]       point_cx,
    input  logic [SYS_BIT_WIDTH-1:0]       point_cy,
    output logic                           valid_out,
    output logic signed [2*SYS_BIT_WIDTH+1:0] value_out,
    output logic                           sign_neg_out,
    output logic                           zero_out
);

    localparam int STAGES = 3;

    point_t pa, pb, pc;
    vec_t   ab_d, ac_d;

    assign pa = '{x: point_ax, y: point_ay};
    assign pb = '{x: point_bx, y: point_by};
    assign pc = '{x: point_cx, y: point_cy};

    point_sub u_sub_ab (.a_i(pa), .b_i(pb), .d_o(ab_d));
    point_sub u_sub_ac (.a_i(pa), .b_i(pc), .d_o(ac_d));

    logic [STAGES-1:0]       vld_pipe_q;
    vec_t                    ab_q, ac_q;
    logic signed [CP_W-1:0]  p1_q, p2_q, p1_d, p2_d, diff_d;
    logic signed [CP_W-1:0]  value_q;
    logic                    neg_q, zero_q;

    // Widths are chosen so the products and their difference are exact.
    assign p1_d   = $signed(ab_q.x) * $signed(ac_q.y);
    assign p2_d   = $signed(ab_q.y) * $signed(ac_q.x);
    assign diff_d = p1_q - p2_q;

    // Valid shift register; each stage's data loads only when its valid bit is set.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            vld_pipe_q <= '0;
            ab_q       <= '0;
            ac_q       <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            value_q    <= '0;
            neg_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-2:0], valid_in};
            if (valid_in) begin
                ab_q <= ab_d;
                ac_q <= ac_d;
            end
            if (vld_pipe_q[0]) begin
                p1_q <= p1_d;
                p2_q <= p2_d;
            end
            if (vld_pipe_q[1]) begin
                value_q <= diff_d;
                neg_q   <= diff_d[CP_W-1];
                zero_q  <= (diff_d == '0);
            end
        end
    end

    assign valid_out    = vld_pipe_q[STAGES-1];
    assign value_out    = value_q;
    assign sign_neg_out = neg_q;
    assign zero_out     = zero_q;

endmodule

// File: tb/tb_tri_edge_cross.sv
// Scoreboard bench for tri_edge_cross: driver pushes reference results, monitor pops on valid_out.
module tb_tri_edge_cross;

    localparam int W = 6;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic                 clk, rst_n, valid_in;
    logic [W-1:0]         ax, ay, bx, by, cx, cy;
    logic                 valid_out, sign_neg_out, zero_out;
    logic signed [2*W+1:0] value_out;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_val = 0;

    tri_edge_cross #(.SYS_BIT_WIDTH(W)) dut (
        .clk_in      (clk),
        .rst_n_in    (rst_n),
        .valid_in    (valid_in),
        .point_ax    (ax),
        .point_ay    (ay),
        .point_bx    (bx),
        .point_by    (by),
        .point_cx    (cx),
        .point_cy    (cy),
        .valid_out   (valid_out),
        .value_out   (value_out),
        .sign_neg_out(sign_neg_out),
        .zero_out    (zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Geometric reference: cross(B-A, C-A) with plain integer arithmetic.
    function automatic int ref_cross(int pax, int pay, int pbx, int pby, int pcx, int pcy);
        return (pbx - pax) * (pcy - pay) - (pby - pay) * (pcx - pax);
    endfunction

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic junk_inputs();
        ax = W'($urandom); ay = W'($urandom); bx = W'($urandom);
        by = W'($urandom); cx = W'($urandom); cy = W'($urandom);
    endtask

    // Issue one triangle for one cycle; caller is right after a rising edge.
    task automatic send(int pax, int pay, int pbx, int pby, int pcx, int pcy);
        exp_t e;
        ax = W'(pax); ay = W'(pay); bx = W'(pbx); by = W'(pby); cx = W'(pcx); cy = W'(pcy);
        valid_in = 1'b1;
        e.val = ref_cross(pax, pay, pbx, pby, pcx, pcy);
        e.cyc = cyc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        valid_in = 1'b0;
        junk_inputs();
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            junk_inputs();
        end
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: compare on valid_out, otherwise outputs must hold the last result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got value %0d expected no output", value_out);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("value", int'(value_out), e.val);
                    chk("sign_neg", int'(sign_neg_out), int'(e.val < 0));
                    chk("zero", int'(zero_out), int'(e.val == 0));
                    chk("latency", cyc - e.cyc, 3);
                    last_val = e.val;
                end
            end else begin
                chk("hold_value", int'(value_out), last_val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        junk_inputs();
        idle(3);
        chk("reset_valid", int'(valid_out), 0);
        chk("reset_value", int'(value_out), 0);
        chk("reset_neg", int'(sign_neg_out), 0);
        chk("reset_zero", int'(zero_out), 0);
        rst_n = 1'b1;
        idle(2);

        // Directed cases from the geometry.
        send(0, 0, 10, 30, 20, 0);    idle(4);
        send(0, 0, 20, 0, 10, 30);    idle(4);
        send(5, 5, 10, 10, 20, 20);   idle(4);
        send(63, 0, 0, 63, 63, 63);   idle(4);
        send(0, 63, 63, 0, 0, 0);     idle(4);
        send(63, 63, 0, 63, 63, 0);   idle(4);
        drain();

        // Back-to-back alternating orientation.
        send(0, 0, 10, 30, 20, 0);
        send(0, 0, 20, 0, 10, 30);
        send(0, 0, 10, 30, 20, 0);
        send(0, 0, 20, 0, 10, 30);
        drain();

        // Reset one cycle after a valid_in: triangle is discarded, outputs clear.
        send(0, 0, 20, 0, 10, 30);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        last_val = 0;
        chk("midreset_value", int'(value_out), 0);
        chk("midreset_neg", int'(sign_neg_out), 0);
        chk("midreset_zero", int'(zero_out), 0);
        chk("midreset_valid", int'(valid_out), 0);
        rst_n = 1'b1;
        idle(5);
        send(0, 0, 10, 30, 20, 0);
        drain();

        // Randomized triangles with random gaps, including back-to-back bursts.
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
        end
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
